// File: rtl/ga_video_serializer.sv
// ga_video_serializer
//   Pixel serializer and palette stage for the CPC/Plus video path. One
//   video byte is loaded per character slot, shifted out at a rate set by
//   the video mode, decoded into 4-bit ink indices, delayed by a
//   programmable soft-scroll amount and mapped through the ink/border
//   palette into a registered output colour.
//
// Ports
//   clk_16       16 MHz pixel clock
//   reset        synchronous, active-high
//   vid_load     one-cycle strobe: vid_data / vid_dispen valid
//   vid_data     video byte
//   vid_dispen   display enable that travels with vid_data
//   hsync        CRTC HSYNC; rising edge applies pending mode/scroll
//   force_blank  forces black output
//   mode_we      write strobe for mode_in
//   mode_in      requested video mode
//   scroll_we    write strobe for scroll_in
//   scroll_in    requested scroll delay, clamped to MAX_SCROLL
//   ink_we       palette write strobe
//   ink_addr     0..15 ink, 16 border, 17..31 ignored
//   ink_data     palette value
//   pix_color    registered output colour
//   pix_blank    registered, 1 while output is forced black
//   cur_mode     currently applied mode

module ga_video_serializer #(
  parameter int COLOR_W        = 5,
  parameter int MAX_SCROLL     = 15,
  parameter int MODE_IMMEDIATE = 0
) (
  input  logic               clk_16,
  input  logic               reset,
  input  logic               vid_load,
  input  logic [7:0]         vid_data,
  input  logic               vid_dispen,
  input  logic               hsync,
  input  logic               force_blank,
  input  logic               mode_we,
  input  logic [1:0]         mode_in,
  input  logic               scroll_we,
  input  logic [3:0]         scroll_in,
  input  logic               ink_we,
  input  logic [4:0]         ink_addr,
  input  logic [COLOR_W-1:0] ink_data,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_blank,
  output logic [1:0]         cur_mode
);

  // one pixel in flight: ink index plus the display enable of its byte
  typedef struct packed {
    logic [3:0] idx;
    logic       en;
  } pix_t;

  localparam logic [3:0] SCROLL_MAX = 4'(MAX_SCROLL);

  // ---------------------------------------------------------------------
  // Mode / scroll registers
  // ---------------------------------------------------------------------
  logic [1:0] pend_mode;
  logic [3:0] pend_scroll, cur_scroll;
  logic       hsync_q;
  logic [3:0] scroll_sat;
  logic [1:0] mode_nxt;
  logic [3:0] scroll_nxt;
  logic       apply;

  assign scroll_sat = (scroll_in > SCROLL_MAX) ? SCROLL_MAX : scroll_in;

  // A write in the same cycle as the apply event goes straight through.
  assign mode_nxt   = mode_we   ? mode_in    : pend_mode;
  assign scroll_nxt = scroll_we ? scroll_sat : pend_scroll;

  generate
    if (MODE_IMMEDIATE != 0) begin : g_apply_load
      assign apply = vid_load;
    end else begin : g_apply_hsync
      assign apply = hsync & ~hsync_q;
    end
  endgenerate

  always_ff @(posedge clk_16) begin
    if (reset) begin
      pend_mode   <= '0;
      cur_mode    <= '0;
      pend_scroll <= '0;
      cur_scroll  <= '0;
      hsync_q     <= 1'b0;
    end else begin
      hsync_q     <= hsync;
      pend_mode   <= mode_nxt;
      pend_scroll <= scroll_nxt;
      if (apply) begin
        cur_mode   <= mode_nxt;
        cur_scroll <= scroll_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Shift register and prescaler
  // ---------------------------------------------------------------------
  logic [7:0] sr;
  logic       dl;
  logic [1:0] pc;
  logic [1:0] tc;

  always_comb begin
    case (cur_mode)
      2'd2:    tc = 2'd0;
      2'd1:    tc = 2'd1;
      default: tc = 2'd3;
    endcase
  end

  // ">=" rather than "==" so a mid-byte switch to a faster mode, with pc
  // already past the new terminal count, shifts on the very next cycle.
  always_ff @(posedge clk_16) begin
    if (reset) begin
      sr <= '0;
      dl <= 1'b0;
      pc <= '0;
    end else if (vid_load) begin
      sr <= vid_data;
      dl <= vid_dispen;
      pc <= '0;
    end else if (pc >= tc) begin
      sr <= {sr[6:0], 1'b0};
      pc <= '0;
    end else begin
      pc <= pc + 2'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Index decode
  // ---------------------------------------------------------------------
  pix_t cur_pix;

  always_comb begin
    cur_pix.en = dl;
    case (cur_mode)
      2'd0:    cur_pix.idx = {sr[1], sr[5], sr[3], sr[7]};
      2'd2:    cur_pix.idx = {3'b000, sr[7]};
      default: cur_pix.idx = {2'b00, sr[3], sr[7]};
    endcase
  end

  // ---------------------------------------------------------------------
  // Soft-scroll delay line; tap 0 is the undelayed pixel
  // ---------------------------------------------------------------------
  pix_t dly [1:MAX_SCROLL];
  pix_t tap;

  always_ff @(posedge clk_16) begin
    if (reset) dly[1] <= '0;
    else       dly[1] <= cur_pix;
  end

  generate
    for (genvar k = 2; k <= MAX_SCROLL; k++) begin : g_dly
      always_ff @(posedge clk_16) begin
        if (reset) dly[k] <= '0;
        else       dly[k] <= dly[k-1];
      end
    end
  endgenerate

  always_comb begin
    tap = cur_pix;
    for (int k = 1; k <= MAX_SCROLL; k++)
      if (cur_scroll == 4'(k)) tap = dly[k];
  end

  // ---------------------------------------------------------------------
  // Palette
  // ---------------------------------------------------------------------
  logic [COLOR_W-1:0] inks [16];
  logic [COLOR_W-1:0] border;

  always_ff @(posedge clk_16) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) inks[i] <= '0;
      border <= '0;
    end else if (ink_we) begin
      if (!ink_addr[4])          inks[ink_addr[3:0]] <= ink_data;
      else if (ink_addr == 5'd16) border             <= ink_data;
    end
  end

  // ---------------------------------------------------------------------
  // Colour select, registered
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_16) begin
    if (reset) begin
      pix_color <= '0;
      pix_blank <= 1'b0;
    end else if (force_blank) begin
      pix_color <= '0;
      pix_blank <= 1'b1;
    end else begin
      pix_blank <= 1'b0;
      pix_color <= tap.en ? inks[tap.idx] : border;
    end
  end

endmodule

// File: tb/tb_ga_video_serializer.sv
module tb_ga_video_serializer;

  logic        clk_16 = 1'b0;
  logic        reset;
  logic        vid_load;
  logic [7:0]  vid_data;
  logic        vid_dispen;
  logic        hsync;
  logic        force_blank;
  logic        mode_we;
  logic [1:0]  mode_in;
  logic        scroll_we;
  logic [3:0]  scroll_in;
  logic        ink_we;
  logic [4:0]  ink_addr;
  logic [11:0] ink_data;

  logic [4:0]  pix_color_a;
  logic        pix_blank_a;
  logic [1:0]  cur_mode_a;
  logic [11:0] pix_color_b;
  logic        pix_blank_b;
  logic [1:0]  cur_mode_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk_16 = ~clk_16;

  // default build: 5-bit colour, 15-step scroll, apply at HSYNC
  ga_video_serializer #(.COLOR_W(5), .MAX_SCROLL(15), .MODE_IMMEDIATE(0)) dut (
    .clk_16(clk_16), .reset(reset), .vid_load(vid_load), .vid_data(vid_data),
    .vid_dispen(vid_dispen), .hsync(hsync), .force_blank(force_blank),
    .mode_we(mode_we), .mode_in(mode_in), .scroll_we(scroll_we),
    .scroll_in(scroll_in), .ink_we(ink_we), .ink_addr(ink_addr),
    .ink_data(ink_data[4:0]), .pix_color(pix_color_a), .pix_blank(pix_blank_a),
    .cur_mode(cur_mode_a));

  // Plus build: 12-bit RGB, 7-step scroll, apply on load
  ga_video_serializer #(.COLOR_W(12), .MAX_SCROLL(7), .MODE_IMMEDIATE(1)) dut2 (
    .clk_16(clk_16), .reset(reset), .vid_load(vid_load), .vid_data(vid_data),
    .vid_dispen(vid_dispen), .hsync(hsync), .force_blank(force_blank),
    .mode_we(mode_we), .mode_in(mode_in), .scroll_we(scroll_we),
    .scroll_in(scroll_in), .ink_we(ink_we), .ink_addr(ink_addr),
    .ink_data(ink_data), .pix_color(pix_color_b), .pix_blank(pix_blank_b),
    .cur_mode(cur_mode_b));

  // inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk_16);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vid_load = 0; vid_data = 0; vid_dispen = 0; hsync = 0; force_blank = 0;
    mode_we = 0; mode_in = 0; scroll_we = 0; scroll_in = 0;
    ink_we = 0; ink_addr = 0; ink_data = 0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wr_ink(input logic [4:0] a, input logic [11:0] d);
    ink_we = 1'b1; ink_addr = a; ink_data = d;
    tick();
    ink_we = 1'b0;
  endtask

  task automatic set_mode_hs(input logic [1:0] m);
    mode_we = 1'b1; mode_in = m;
    tick();
    mode_we = 1'b0;
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
    tick();
  endtask

  // returns in cycle t+1 (load was in cycle t)
  task automatic load_byte(input logic [7:0] d, input logic en);
    vid_load = 1'b1; vid_data = d; vid_dispen = en;
    tick();
    vid_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vid_load = 0; vid_data = 0; vid_dispen = 0; hsync = 0; force_blank = 0;
    mode_we = 0; mode_in = 0; scroll_we = 0; scroll_in = 0;
    ink_we = 0; ink_addr = 0; ink_data = 0;
    tick(); tick();
    checks++; if (pix_color_a !== 5'h00) begin failures++; $display("FAIL reset_color_a got=%h exp=00", pix_color_a); end
    checks++; if (pix_blank_a !== 1'b0) begin failures++; $display("FAIL reset_blank_a got=%b exp=0", pix_blank_a); end
    checks++; if (cur_mode_a !== 2'd0) begin failures++; $display("FAIL reset_mode_a got=%0d exp=0", cur_mode_a); end
    checks++; if (pix_color_b !== 12'h000) begin failures++; $display("FAIL reset_color_b got=%h exp=000", pix_color_b); end
    checks++; if (cur_mode_b !== 2'd0) begin failures++; $display("FAIL reset_mode_b got=%0d exp=0", cur_mode_b); end
    reset = 1'b0;
  endtask

  task automatic test_mode2();
    logic [4:0] exp [8];
    exp = '{5'h0B, 5'h04, 5'h0B, 5'h04, 5'h04, 5'h0B, 5'h04, 5'h0B};
    do_reset();
    wr_ink(5'd0, 12'h004);
    wr_ink(5'd1, 12'h00B);
    set_mode_hs(2'd2);
    load_byte(8'hA5, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (pix_color_a !== exp[i]) begin failures++; $display("FAIL mode2_pix%0d got=%h exp=%h", i, pix_color_a, exp[i]); end
      tick();
    end
  endtask

  task automatic test_mode1();
    logic [4:0] exp [4];
    exp = '{5'h1A, 5'h1A, 5'h02, 5'h02};
    do_reset();
    wr_ink(5'd3, 12'h01A);
    wr_ink(5'd0, 12'h002);
    set_mode_hs(2'd1);
    load_byte(8'h88, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pix_color_a !== exp[i]) begin failures++; $display("FAIL mode1_pix%0d got=%h exp=%h", i, pix_color_a, exp[i]); end
      tick();
    end
  endtask

  task automatic test_mode0();
    do_reset();
    wr_ink(5'd15, 12'h01F);
    wr_ink(5'd0, 12'h003);
    load_byte(8'hAA, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      logic [4:0] e;
      e = (i < 4) ? 5'h1F : 5'h03;
      checks++;
      if (pix_color_a !== e) begin failures++; $display("FAIL mode0_pix%0d got=%h exp=%h", i, pix_color_a, e); end
      tick();
    end
  endtask

  task automatic test_mode_defer();
    do_reset();
    mode_we = 1'b1; mode_in = 2'd2;
    tick();
    mode_we = 1'b0;
    tick(); tick();
    checks++; if (cur_mode_a !== 2'd0) begin failures++; $display("FAIL defer_before_hs got=%0d exp=0", cur_mode_a); end
    hsync = 1'b1;
    tick();
    checks++; if (cur_mode_a !== 2'd2) begin failures++; $display("FAIL defer_after_hs got=%0d exp=2", cur_mode_a); end
    checks++; if (cur_mode_b !== 2'd0) begin failures++; $display("FAIL imm_ignores_hs got=%0d exp=0", cur_mode_b); end
    hsync = 1'b0;
    tick();
    load_byte(8'h00, 1'b0);
    checks++; if (cur_mode_b !== 2'd2) begin failures++; $display("FAIL imm_on_load got=%0d exp=2", cur_mode_b); end
    // write in the same cycle as the HSYNC rise goes straight through
    mode_we = 1'b1; mode_in = 2'd1; hsync = 1'b1;
    tick();
    mode_we = 1'b0; hsync = 1'b0;
    checks++; if (cur_mode_a !== 2'd1) begin failures++; $display("FAIL hs_write_through got=%0d exp=1", cur_mode_a); end
    tick();
  endtask

  task automatic test_scroll();
    do_reset();
    wr_ink(5'd0, 12'h004);
    wr_ink(5'd1, 12'h00B);
    mode_we = 1'b1; mode_in = 2'd2; scroll_we = 1'b1; scroll_in = 4'd5;
    tick();
    mode_we = 1'b0; scroll_we = 1'b0;
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
    tick();
    load_byte(8'h80, 1'b1);
    repeat (5) tick();
    checks++; if (pix_color_a !== 5'h00) begin failures++; $display("FAIL scroll5_t6 got=%h exp=00", pix_color_a); end
    tick();
    checks++; if (pix_color_a !== 5'h0B) begin failures++; $display("FAIL scroll5_t7 got=%h exp=0B", pix_color_a); end
    tick();
    checks++; if (pix_color_a !== 5'h04) begin failures++; $display("FAIL scroll5_t8 got=%h exp=04", pix_color_a); end
  endtask

  task automatic test_scroll_clamp();
    do_reset();
    wr_ink(5'd1, 12'hF0A);
    wr_ink(5'd0, 12'h00C);
    mode_we = 1'b1; mode_in = 2'd2; scroll_we = 1'b1; scroll_in = 4'd15;
    tick();
    mode_we = 1'b0; scroll_we = 1'b0;
    load_byte(8'h80, 1'b1);
    repeat (7) tick();
    checks++; if (pix_color_b !== 12'h000) begin failures++; $display("FAIL clamp_t8 got=%h exp=000", pix_color_b); end
    tick();
    checks++; if (pix_color_b !== 12'hF0A) begin failures++; $display("FAIL clamp_t9 got=%h exp=F0A", pix_color_b); end
  endtask

  task automatic test_border_blank();
    do_reset();
    wr_ink(5'd16, 12'h014);
    wr_ink(5'd20, 12'h01F);
    load_byte(8'hFF, 1'b0);
    tick();
    checks++; if (pix_color_a !== 5'h14) begin failures++; $display("FAIL border got=%h exp=14", pix_color_a); end
    force_blank = 1'b1;
    tick();
    checks++; if (pix_color_a !== 5'h00) begin failures++; $display("FAIL blank_color got=%h exp=00", pix_color_a); end
    checks++; if (pix_blank_a !== 1'b1) begin failures++; $display("FAIL blank_flag got=%b exp=1", pix_blank_a); end
    force_blank = 1'b0;
    tick();
    checks++; if (pix_color_a !== 5'h14 || pix_blank_a !== 1'b0) begin
      failures++; $display("FAIL unblank got=%h/%b exp=14/0", pix_color_a, pix_blank_a); end
  endtask

  task automatic test_palette_rw();
    do_reset();
    wr_ink(5'd3, 12'h123);
    mode_we = 1'b1; mode_in = 2'd1;
    tick();
    mode_we = 1'b0;
    load_byte(8'h88, 1'b1);
    ink_we = 1'b1; ink_addr = 5'd3; ink_data = 12'hF0A;
    tick();
    ink_we = 1'b0;
    checks++; if (pix_color_b !== 12'h123) begin failures++; $display("FAIL pal_old got=%h exp=123", pix_color_b); end
    tick();
    checks++; if (pix_color_b !== 12'hF0A) begin failures++; $display("FAIL pal_new got=%h exp=F0A", pix_color_b); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_ink(5'd1, 12'h01F);
    wr_ink(5'd15, 12'h01F);
    set_mode_hs(2'd2);
    load_byte(8'hFF, 1'b1);
    tick();
    checks++; if (pix_color_a !== 5'h1F) begin failures++; $display("FAIL pre_reset got=%h exp=1F", pix_color_a); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (pix_color_a !== 5'h00) begin failures++; $display("FAIL mid_reset_color got=%h exp=00", pix_color_a); end
    checks++; if (cur_mode_a !== 2'd0) begin failures++; $display("FAIL mid_reset_mode got=%0d exp=0", cur_mode_a); end
    tick();
    checks++; if (pix_color_a !== 5'h00) begin failures++; $display("FAIL byte_discard got=%h exp=00", pix_color_a); end
    load_byte(8'hFF, 1'b1);
    tick();
    checks++; if (pix_color_a !== 5'h00) begin failures++; $display("FAIL inks_cleared got=%h exp=00", pix_color_a); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_ink(5'd0, 12'h004);
    wr_ink(5'd1, 12'h00B);
    set_mode_hs(2'd2);
    load_byte(8'hA5, 1'b1);
    tick();
    checks++; if (pix_color_a !== 5'h0B) begin failures++; $display("FAIL b2b_t2 got=%h exp=0B", pix_color_a); end
    tick();
    checks++; if (pix_color_a !== 5'h04) begin failures++; $display("FAIL b2b_t3 got=%h exp=04", pix_color_a); end
    load_byte(8'hFF, 1'b1);
    checks++; if (pix_color_a !== 5'h0B) begin failures++; $display("FAIL b2b_t4 got=%h exp=0B", pix_color_a); end
    tick();
    checks++; if (pix_color_a !== 5'h0B) begin failures++; $display("FAIL b2b_t5 got=%h exp=0B", pix_color_a); end
    tick();
    checks++; if (pix_color_a !== 5'h0B) begin failures++; $display("FAIL b2b_t6 got=%h exp=0B", pix_color_a); end
  endtask

  initial begin
    test_reset();
    test_mode2();
    test_mode1();
    test_mode0();
    test_mode_defer();
    test_scroll();
    test_scroll_clamp();
    test_border_blank();
    test_palette_rw();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
